// File: rtl/rtlola_pkg.sv
// Shared definitions for the RTLola monitor front end.
// Holds the default data and timestamp widths and the system clock rate.
// Also holds the default tick periods for the four monitor rates (10/5/2/1 Hz)
// and the buffered event record type.
package rtlola_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TS_W   = 48;
    localparam int unsigned CLK_HZ = 100_000_000;

    localparam int unsigned PERIOD_0_DEF = CLK_HZ / 10;
    localparam int unsigned PERIOD_1_DEF = CLK_HZ / 5;
    localparam int unsigned PERIOD_2_DEF = CLK_HZ / 2;
    localparam int unsigned PERIOD_3_DEF = CLK_HZ;

    // One buffered input event. The timestamp field is called stamp because
    // "time" is a reserved word.
    typedef struct packed {
        logic signed [DATA_W-1:0] data;
        logic [TS_W-1:0]          stamp;
    } event_t;

endpackage

// File: rtl/rtlola_rate_divider.sv
// Enable-tick generator for one periodic monitor rate.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   en   - global enable; low freezes the counter and forces tick low
//   tick - high for one enabled cycle out of every PERIOD enabled cycles
module rtlola_rate_divider #(
    parameter int unsigned PERIOD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(PERIOD + 1);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    always_comb begin
        at_last = (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (en) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
        // Gated by rst so that a period of 1 cannot tick while in reset.
        tick = en & rst & at_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtlola_input_pacer.sv
// Front end of the RTLola monitor.
// Timestamps asynchronous input events with a free-running cycle counter.
// Buffers the events in a small FIFO that has a valid/ready head, and
// generates the four per-rate enable ticks.
// Ports:
//   clk, rst            - system clock, asynchronous active-low reset
//   en                  - global enable; low freezes every piece of state
//   in_valid, in_data   - input event strobe and signed value
//   out_valid/ready     - head-of-FIFO handshake
//   out_data, out_time  - head event value and its cycle timestamp
//   tick[3:0]           - one-cycle enable pulse per rate
//   overflow            - sticky, an event was dropped on a full FIFO
//   level               - FIFO occupancy
module rtlola_input_pacer
    import rtlola_pkg::*;
#(
    parameter int unsigned DATA_W   = rtlola_pkg::DATA_W,
    parameter int unsigned TS_W     = rtlola_pkg::TS_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PERIOD_0 = rtlola_pkg::PERIOD_0_DEF,
    parameter int unsigned PERIOD_1 = rtlola_pkg::PERIOD_1_DEF,
    parameter int unsigned PERIOD_2 = rtlola_pkg::PERIOD_2_DEF,
    parameter int unsigned PERIOD_3 = rtlola_pkg::PERIOD_3_DEF,
    localparam int unsigned LW      = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [TS_W-1:0]          out_time,
    output logic [3:0]               tick,
    output logic                     overflow,
    output logic [LW-1:0]            level
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic signed [DATA_W-1:0] data;
        logic [TS_W-1:0]          stamp;
    } slot_t;

    slot_t           mem_q [DEPTH];
    slot_t           mem_d [DEPTH];
    logic [TS_W-1:0] ts_q, ts_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            overflow_q, overflow_d;
    logic            full, pop, push, drop;

    always_comb begin
        full = (level_q == LW'(DEPTH));
        pop  = en & (level_q != '0) & out_ready;
        // A pop in the same cycle frees the slot the push needs.
        push = en & in_valid & (~full | pop);
        drop = en & in_valid & full & ~pop;

        mem_d      = mem_q;
        ts_d       = ts_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | drop;

        if (en) begin
            ts_d = ts_q + 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q] = '{data: in_data, stamp: ts_q};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Head is read straight out of the storage flops, so it is registered and
    // holds while the monitor stalls; storage resets to zero for the reset head.
    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q].data;
    assign out_time  = mem_q[rd_ptr_q].stamp;
    assign overflow  = overflow_q;
    assign level     = level_q;

    rtlola_rate_divider #(.PERIOD(PERIOD_0)) u_div0 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick[0])
    );

    rtlola_rate_divider #(.PERIOD(PERIOD_1)) u_div1 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick[1])
    );

    rtlola_rate_divider #(.PERIOD(PERIOD_2)) u_div2 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick[2])
    );

    rtlola_rate_divider #(.PERIOD(PERIOD_3)) u_div3 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick[3])
    );

endmodule
